// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the serial SECDED decoder.
package secded_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYND,
      ST_EMIT
   } dec_state_t;

   // Smallest p with 2^p >= data_w + p + 1.
   function automatic int unsigned calc_p_w(input int unsigned data_w);
      int unsigned p;
      p = 1;
      while ((32'd1 << p) < data_w + p + 1) p++;
      return p;
   endfunction

   function automatic logic is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   // Codeword position carrying data bit idx (positions 0 and 2^k are parity).
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned n;
      n = 0;
      for (int unsigned p = 3; p < 256; p++) begin
         if (!is_pow2(p)) begin
            if (n == idx) return p;
            n++;
         end
      end
      return 0;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module secded_syndrome #(
   parameter int unsigned CW_W = 72,
   parameter int unsigned P_W  = 7
) (
   input  logic [CW_W-1:0] cw,
   output logic [P_W-1:0]  syndrome,
   output logic            parity
);

   always_comb begin
      syndrome = '0;
      parity   = ^cw;
      for (int unsigned i = 1; i < CW_W; i++) begin
         if (cw[i]) syndrome = syndrome ^ P_W'(i);
      end
   end

endmodule

// File: rtl/serial_secded_decoder.sv
// Bit-serial SECDED decoder with error history; optional saturating error
// counters are built when SECDED_ERR_COUNTERS_EN is defined.
module serial_secded_decoder
   import secded_pkg::*;
#(
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned HIST_DEPTH    = 8,
   parameter int          CORR_THRESH   = 4,
   parameter int          UNCORR_THRESH = 3,
   localparam int unsigned P_W          = calc_p_w(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              serial_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              error_detected,
   output logic              error_corrected,
   output logic              uncorrectable,
   output logic [P_W:0]      err_pos,
   output logic              frequent_errors
`ifdef SECDED_ERR_COUNTERS_EN
   ,
   input  logic              clear_counts,
   output logic [15:0]       corr_count,
   output logic [15:0]       uncorr_count
`endif
);

   localparam int unsigned CW_W  = DATA_W + P_W + 1;
   localparam int unsigned CNT_W = $clog2(CW_W);
   localparam logic [P_W:0] CW_LIM = (P_W + 1)'(CW_W);

   logic [CNT_W-1:0]      bit_cnt;
   logic [CW_W-2:0]       shift_reg;
   logic [CW_W-1:0]       next_word;
   logic [CW_W-1:0]       dec_word;
   logic                  last_bit;

   dec_state_t            state;
   logic [P_W-1:0]        syn_c, syn_q;
   logic                  par_c, par_q;
   logic                  syn_nz, in_range, flip_en, corr_any, unc_any;
   logic [DATA_W-1:0]     corr_data;
   logic [HIST_DEPTH-1:0] corr_hist, unc_hist;
   logic [HIST_DEPTH-1:0] corr_hist_nx, unc_hist_nx;

   assign next_word = {shift_reg, serial_in};
   assign last_bit  = serial_valid && (bit_cnt == CNT_W'(CW_W - 1));

   // The final bit goes straight into the decode register so the next frame
   // can start on the very next valid cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         dec_word  <= '0;
      end else if (serial_valid) begin
         shift_reg <= next_word[CW_W-2:0];
         bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         if (last_bit) dec_word <= next_word;
      end
   end

   secded_syndrome #(
      .CW_W (CW_W),
      .P_W  (P_W)
   ) u_syndrome (
      .cw       (dec_word),
      .syndrome (syn_c),
      .parity   (par_c)
   );

   assign syn_nz   = |syn_q;
   assign in_range = {1'b0, syn_q} < CW_LIM;
   assign flip_en  = par_q & syn_nz & in_range;
   assign corr_any = par_q & (~syn_nz | in_range);
   assign unc_any  = syn_nz & (~par_q | ~in_range);

   for (genvar d = 0; d < DATA_W; d++) begin : g_data
      localparam int unsigned POS = data_pos(d);
      assign corr_data[d] = dec_word[POS] ^ (flip_en && (syn_q == P_W'(POS)));
   end

   assign corr_hist_nx = {corr_hist[HIST_DEPTH-2:0], corr_any};
   assign unc_hist_nx  = {unc_hist[HIST_DEPTH-2:0], unc_any};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         syn_q           <= '0;
         par_q           <= 1'b0;
         out_valid       <= 1'b0;
         data_out        <= '0;
         error_detected  <= 1'b0;
         error_corrected <= 1'b0;
         uncorrectable   <= 1'b0;
         err_pos         <= '0;
         corr_hist       <= '0;
         unc_hist        <= '0;
         frequent_errors <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: if (last_bit) state <= ST_SYND;
            ST_SYND: begin
               syn_q <= syn_c;
               par_q <= par_c;
               state <= ST_EMIT;
            end
            ST_EMIT: begin
               out_valid       <= 1'b1;
               data_out        <= corr_data;
               error_detected  <= par_q | syn_nz;
               error_corrected <= corr_any;
               uncorrectable   <= unc_any;
               err_pos         <= flip_en ? {1'b0, syn_q} : '0;
               corr_hist       <= corr_hist_nx;
               unc_hist        <= unc_hist_nx;
               frequent_errors <= ($countones(corr_hist_nx) >= CORR_THRESH) ||
                                  ($countones(unc_hist_nx) >= UNCORR_THRESH);
               state           <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SECDED_ERR_COUNTERS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (clear_counts) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (state == ST_EMIT) begin
         if (corr_any && corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
         if (unc_any && uncorr_count != 16'hFFFF) uncorr_count <= uncorr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_secded_decoder.sv
// Scoreboard bench for serial_secded_decoder at default parameters.
module tb_serial_secded_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        serial_in = 1'b0;
   logic        serial_valid = 1'b0;
   logic [63:0] data_out;
   logic        out_valid, error_detected, error_corrected, uncorrectable;
   logic [7:0]  err_pos;
   logic        frequent_errors;
`ifdef SECDED_ERR_COUNTERS_EN
   logic        clear_counts = 1'b0;
   logic [15:0] corr_count, uncorr_count;
`endif

   serial_secded_decoder dut (
      .clk             (clk),
      .reset           (reset),
      .serial_in       (serial_in),
      .serial_valid    (serial_valid),
      .data_out        (data_out),
      .out_valid       (out_valid),
      .error_detected  (error_detected),
      .error_corrected (error_corrected),
      .uncorrectable   (uncorrectable),
      .err_pos         (err_pos),
      .frequent_errors (frequent_errors)
`ifdef SECDED_ERR_COUNTERS_EN
      ,
      .clear_counts    (clear_counts),
      .corr_count      (corr_count),
      .uncorr_count    (uncorr_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      logic        ed, ec, unc;
      logic [7:0]  pos;
      logic        freq;
      int          cap;
      int          id;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int next_id = 0;

   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s frame=%0d actual=%h required=%h", nm, id, act, req);
      end
   endtask

   function automatic logic [71:0] encode(input logic [63:0] d);
      logic [71:0] cw;
      logic        b;
      int          n;
      cw = '0;
      n = 0;
      for (int p = 3; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[n];
            n++;
         end
      end
      for (int k = 0; k < 7; k++) begin
         b = 1'b0;
         for (int p = 1; p < 72; p++) if (((p >> k) & 1) == 1) b = b ^ cw[p];
         cw[1 << k] = b;
      end
      cw[0] = ^cw[71:1];
      return cw;
   endfunction

   function automatic logic [71:0] flip(input logic [71:0] cw, input int p);
      return cw ^ (72'd1 << p);
   endfunction

   // Sends one frame MSB (position 71) first; gap_at inserts idle cycles.
   task automatic send_frame(input logic [71:0] cw, input logic [63:0] d,
                             input logic ed, input logic ec, input logic unc,
                             input logic [7:0] pos, input logic freq, input int gap_at);
      exp_t e;
      for (int i = 71; i >= 0; i--) begin
         if (i == gap_at) begin
            serial_valid = 1'b0;
            serial_in    = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
         end
         serial_in    = cw[i];
         serial_valid = 1'b1;
         @(posedge clk); #1;
      end
      serial_valid = 1'b0;
      e.data = d; e.ed = ed; e.ec = ec; e.unc = unc; e.pos = pos; e.freq = freq;
      e.cap = cyc; e.id = next_id;
      next_id++;
      q.push_back(e);
   endtask

   task automatic send_partial(input logic [71:0] cw, input int nbits);
      for (int i = 71; i > 71 - nbits; i--) begin
         serial_in    = cw[i];
         serial_valid = 1'b1;
         @(posedge clk); #1;
      end
      serial_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) begin @(posedge clk); #1; end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", -1, 64'(out_valid), 64'd0);
      chk("rst_data_out", -1, data_out, 64'd0);
      chk("rst_flags", -1, 64'({error_detected, error_corrected, uncorrectable}), 64'd0);
      chk("rst_err_pos", -1, 64'(err_pos), 64'd0);
      chk("rst_frequent", -1, 64'(frequent_errors), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: every out_valid pulse is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid at cycle %0d actual=1 required=0", cyc);
            end else begin
               e = q.pop_front();
               chk("latency", e.id, 64'(cyc - e.cap), 64'd2);
               chk("data_out", e.id, data_out, e.data);
               chk("error_detected", e.id, 64'(error_detected), 64'(e.ed));
               chk("error_corrected", e.id, 64'(error_corrected), 64'(e.ec));
               chk("uncorrectable", e.id, 64'(uncorrectable), 64'(e.unc));
               chk("err_pos", e.id, 64'(err_pos), 64'(e.pos));
               chk("frequent_errors", e.id, 64'(frequent_errors), 64'(e.freq));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [71:0] c0;
      c0 = encode(D0);
      @(posedge clk); #1;
      do_reset();

      send_frame(c0, D0, 0, 0, 0, 8'd0, 0, -1);
      send_frame(flip(c0, 37), D0, 1, 1, 0, 8'd37, 0, -1);
      send_frame(flip(flip(c0, 5), 9), 64'h0123_4567_89AB_CDFD, 1, 0, 1, 8'd0, 0, -1);
      send_frame(flip(c0, 0), D0, 1, 1, 0, 8'd0, 0, -1);
      // Odd error count with syndrome 83 (>= 72): out of range
      send_frame(flip(flip(flip(c0, 3), 17), 65), 64'h0323_4567_89AB_C5EE, 1, 0, 1, 8'd0, 0, -1);
      // Third uncorrectable in history reaches the threshold
      send_frame(flip(flip(c0, 71), 70), 64'hC123_4567_89AB_CDEF, 1, 0, 1, 8'd0, 1, -1);
      wait_drain();
      do_reset();

      send_frame(flip(encode(64'hFFFF_FFFF_FFFF_FFFF), 1), 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 8'd1, 0, -1);
      send_frame(encode(64'h0), 64'h0, 0, 0, 0, 8'd0, 0, 30);
      send_frame(flip(encode(64'hA5A5_A5A5_5A5A_5A5A), 71), 64'hA5A5_A5A5_5A5A_5A5A, 1, 1, 0, 8'd71, 0, -1);
      send_frame(encode(64'hDEAD_BEEF_CAFE_F00D), 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 8'd0, 0, -1);
      send_frame(flip(encode(64'h8000_0000_0000_0001), 10), 64'h8000_0000_0000_0001, 1, 1, 0, 8'd10, 0, -1);
      send_frame(flip(encode(64'h1234_5678_9ABC_DEF0), 50), 64'h1234_5678_9ABC_DEF0, 1, 1, 0, 8'd50, 1, -1);
      send_frame(encode(64'h0F0F_0F0F_0F0F_0F0F), 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 0, 8'd0, 1, -1);
      send_frame(c0, D0, 0, 0, 0, 8'd0, 1, -1);
      wait_drain();

      send_partial(c0, 40);
      do_reset();
      send_frame(c0, D0, 0, 0, 0, 8'd0, 0, -1);
      wait_drain();

      repeat (5) begin @(posedge clk); #1; end
      chk("hold_data_out", -1, data_out, D0);
      chk("idle_out_valid", -1, 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
